mem_load_unit: RTL and testbench
================================

Name: mem_load_unit

Overview:
- Parametrised successor to the single-cycle memory stage. Replaces the fixed-latency SRAM read with a variable-latency data-memory interface using valid/ready handshakes.
- Holds up to DEPTH outstanding loads in an in-order metadata/result queue. Extracts and extends each load result by size/offset, then presents it as a writeback record. Sits between EX and WB.
- Stores are posted and produce no response. A flush kills all in-flight loads without stalling the memory interface.

Parameters:
- XLEN, 64, address and register width.
- DATA_WD, 64, data-memory bus width; power of 2, at least 32.
- DEPTH, 4, maximum outstanding loads; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  kill all in-flight loads
- req_valid  in  1  EX request valid
- req_ready  out  1  request accepted this cycle
- req_we  in  1  1=store, 0=load
- req_addr  in  XLEN  byte address
- req_size  in  2  0=B, 1=H, 2=W, 3=D (D is legal only if DATA_WD=64)
- req_unsigned  in  1  zero-extend load
- req_rd  in  5  destination register
- req_wdata  in  XLEN  store data, right-aligned
- misalign_err  out  1  one-cycle pulse: misaligned request consumed and dropped
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  store
- dmem_addr  out  XLEN  address aligned to DATA_WD/8
- dmem_wdata  out  DATA_WD  store data shifted to lane
- dmem_wstrb  out  DATA_WD/8  byte enables
- dmem_rsp_valid  in  1  load response, in order, no backpressure
- dmem_rsp_rdata  in  DATA_WD  raw response word
- wb_valid  out  1  writeback record valid
- wb_ready  in  1  WB accepts
- wb_rd  out  5  destination
- wb_data  out  XLEN  extended load result

Behaviour:
- Queue: DEPTH entries; each holds {rd, size, unsigned, offset, done, kill, data}. Head/tail pointers wrap modulo DEPTH; occupancy count runs 0..DEPTH.
- Misalignment: a request is misaligned when offset is not a multiple of 2^size. Such a request gets req_ready=1 and misalign_err=1. It is not forwarded to memory and not enqueued.
- Aligned requests: req_ready = dmem_req_ready & ~flush & (req_we | count<DEPTH). A push is blocked at count==DEPTH even if a pop happens in the same cycle.
- dmem_req_valid = req_valid & aligned & ~flush & (req_we | count<DEPTH).
- dmem_wstrb sets 2^size bytes starting at the offset. dmem_wdata is req_wdata replicated or shifted left by offset*8.
- Load fire pushes an entry at tail with done=0, kill=0.
- Response handling: dmem_rsp_valid writes rdata into the oldest entry with done=0 and sets its done bit. A response arriving with no pending entry is ignored (protocol violation; the bench asserts this never happens).
- Output: wb_valid = head.done & ~head.kill. Output is combinational from the head entry, so a response is visible on wb the cycle after it arrives.
- wb_data: select rdata bytes [offset*8 +: 8<<size], then sign- or zero-extend to XLEN.
- Pop: head pops when (wb_valid & wb_ready) or (head.done & head.kill). A killed entry is popped silently, one per cycle.
- Flush: sets kill on every occupied entry that same edge and blocks acceptance that cycle. Killed entries keep occupancy until their response returns and they pop. A new push in the cycle after flush is allowed.
- Simultaneous events:
  - Push, response and pop may all occur in one cycle; count updates by +push-pop.
  - A response may target the entry pushed earlier in that cycle's queue state, but never the one being pushed.
- Reset: pointers, count, all done/kill bits = 0; wb_valid=0, misalign_err=0, dmem_req_valid=0, req_ready=0. Reset mid-operation abandons outstanding memory transactions; the environment must also reset memory.

Optional Feature:
- MEM_LOAD_PERF_EN defined: adds outputs perf_loads[31:0] and perf_full_cycles[31:0].
  - perf_loads counts loads retired to wb; killed loads are excluded.
  - perf_full_cycles counts cycles where req_valid is asserted and a load is blocked only by count==DEPTH.
  - Both wrap at 2^32 and clear on rst.
- Undefined: both ports and counters are absent.

Test Plan:
- Load W at addr 0x1004, unsigned=0, rd=5; response 0x80000000_00000000 one cycle after issue -> wb_valid with wb_rd=5, wb_data=0xFFFFFFFF_80000000.
- Four back-to-back loads, dmem_req_ready=1, no responses -> req_ready=0 on the fifth load. Return one response -> fifth accepted the cycle after the pop.
- Store H at 0x2006 with wdata 0xBEEF -> dmem_wstrb=0xC0, dmem_wdata[63:48]=0xBEEF, queue count unchanged.
- Load H at 0x2003 -> misalign_err pulse, dmem_req_valid=0, no queue entry.
- Two loads outstanding, flush, then two responses -> wb_valid never asserts, count returns to 0. A following load issues normally.
- wb_ready=0 for 3 cycles with head done -> wb_valid, wb_rd and wb_data stay stable. Responses still accepted into later entries.

Source files
------------

// File: rtl/mem_load_unit_if.sv
// mem_load_unit_if: bundles the EX request channel, the data-memory
// request/response channel and the writeback channel of mem_load_unit.
//   master : used by mem_load_unit (drives req_ready, misalign_err, dmem_*
//            request fields and the wb_* record)
//   slave  : used by the surrounding pipeline / memory model
// Request  : req_valid/req_ready, req_we, req_addr, req_size, req_unsigned,
//            req_rd, req_wdata, misalign_err, flush
// Memory   : dmem_req_valid/dmem_req_ready, dmem_we, dmem_addr, dmem_wdata,
//            dmem_wstrb, dmem_rsp_valid, dmem_rsp_rdata
// Writeback: wb_valid/wb_ready, wb_rd, wb_data
interface mem_load_unit_if #(
  parameter int XLEN    = 64,
  parameter int DATA_WD = 64
);
  logic                   flush;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [XLEN-1:0]        req_addr;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [4:0]             req_rd;
  logic [XLEN-1:0]        req_wdata;
  logic                   misalign_err;

  logic                   dmem_req_valid;
  logic                   dmem_req_ready;
  logic                   dmem_we;
  logic [XLEN-1:0]        dmem_addr;
  logic [DATA_WD-1:0]     dmem_wdata;
  logic [DATA_WD/8-1:0]   dmem_wstrb;
  logic                   dmem_rsp_valid;
  logic [DATA_WD-1:0]     dmem_rsp_rdata;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [4:0]             wb_rd;
  logic [XLEN-1:0]        wb_data;

  modport master (
    input  flush, req_valid, req_we, req_addr, req_size, req_unsigned,
           req_rd, req_wdata,
    output req_ready, misalign_err,
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready
  );

  modport slave (
    output flush, req_valid, req_we, req_addr, req_size, req_unsigned,
           req_rd, req_wdata,
    input  req_ready, misalign_err,
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/mem_load_unit.sv
// mem_load_unit: memory stage between EX and WB with a variable-latency
// data-memory interface. Loads are tracked in an in-order queue of DEPTH
// entries; responses fill the oldest unanswered entry, and the head entry is
// extracted/extended and presented as a writeback record. Stores are posted.
// A flush kills all in-flight loads; killed entries drain silently once their
// response has returned.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (master)  : request, data-memory and writeback channels
//                   (see mem_load_unit_if)
//   perf_loads, perf_full_cycles : only when MEM_LOAD_PERF_EN is defined;
//                   retired-load count and full-queue stall cycles.
module mem_load_unit #(
  parameter int XLEN    = 64,
  parameter int DATA_WD = 64,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_LOAD_PERF_EN
  output logic [31:0] perf_loads,
  output logic [31:0] perf_full_cycles,
`endif
  mem_load_unit_if.master bus
);

  localparam int NB    = DATA_WD / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = (XLEN > DATA_WD) ? XLEN : DATA_WD;
  localparam int TOPD  = (EW > 63) ? 63 : EW - 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // Queue storage
  logic [4:0]         rd_q   [DEPTH];
  logic [1:0]         size_q [DEPTH];
  logic               uns_q  [DEPTH];
  logic [OFF_W-1:0]   off_q  [DEPTH];
  logic               done_q [DEPTH];
  logic               kill_q [DEPTH];
  logic [DATA_WD-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]   head, tail, rsp_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     pend;   // entries still waiting for their response

  logic [OFF_W-1:0]   req_off;
  logic [OFF_W-1:0]   align_mask;
  logic [NB-1:0]      lane_mask;
  logic               misaligned;
  logic               full;
  logic               accept_ok;
  logic               push, pop, rsp_take;
  logic               head_done, head_kill;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  assign req_off = bus.req_addr[OFF_W-1:0];
  assign full    = (count == DEPTH_C);

  always_comb begin
    align_mask = OFF_W'((32'd1 << bus.req_size) - 32'd1);
    // A doubleword on a 32-bit bus cannot be served; it is dropped like any
    // other misaligned access.
    misaligned = (|(req_off & align_mask)) ||
                 ((bus.req_size == 2'd3) && (DATA_WD < 64));
    lane_mask  = NB'((32'd1 << (32'd1 << bus.req_size)) - 32'd1);
  end

  assign accept_ok = bus.dmem_req_ready & ~bus.flush & (bus.req_we | ~full);

  assign bus.req_ready      = ~rst & (misaligned | accept_ok);
  assign bus.misalign_err   = ~rst & bus.req_valid & misaligned;
  assign bus.dmem_req_valid = ~rst & bus.req_valid & ~misaligned & ~bus.flush &
                              (bus.req_we | ~full);
  assign bus.dmem_we        = bus.req_we;
  assign bus.dmem_addr      = {bus.req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.dmem_wstrb     = lane_mask << req_off;
  assign bus.dmem_wdata     = DATA_WD'(bus.req_wdata) << {req_off, 3'b000};

  assign push = bus.dmem_req_valid & bus.dmem_req_ready & ~bus.req_we;

  // ---------------------------------------------------------------------------
  // Response / writeback side
  // ---------------------------------------------------------------------------
  assign rsp_take  = bus.dmem_rsp_valid & (pend != '0);
  assign head_done = done_q[head] & (count != '0);
  assign head_kill = kill_q[head];

  assign bus.wb_valid = ~rst & head_done & ~head_kill;
  assign pop          = head_done & (head_kill | bus.wb_ready);
  assign bus.wb_rd    = rd_q[head];

  logic [EW-1:0]   sh;
  logic [XLEN-1:0] ext;
  logic            sign;
  int unsigned     nbits;

  always_comb begin
    sh    = EW'(data_q[head]) >> {off_q[head], 3'b000};
    nbits = 32'd8 << size_q[head];
    case (size_q[head])
      2'd0:    sign = sh[7];
      2'd1:    sign = sh[15];
      2'd2:    sign = sh[31];
      default: sign = sh[TOPD];
    endcase
    sign = sign & ~uns_q[head];
    ext  = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      ext[i] = (i < nbits) ? sh[i] : sign;
    end
  end

  assign bus.wb_data = ext;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  // Pointer collisions cannot occur: push and pop share a slot only when the
  // queue is empty or full; a response never targets a done (poppable) entry
  // nor the entry being pushed, since pend excludes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      rsp_ptr <= '0;
      count   <= '0;
      pend    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        done_q[i] <= 1'b0;
        kill_q[i] <= 1'b0;
      end
    end else begin
      // Killing free slots too is harmless: a push re-initialises the slot.
      if (bus.flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) kill_q[i] <= 1'b1;
      end
      if (rsp_take) begin
        done_q[rsp_ptr] <= 1'b1;
        rsp_ptr         <= rsp_ptr + 1'b1;
      end
      if (pop) begin
        done_q[head] <= 1'b0;
        kill_q[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        done_q[tail] <= 1'b0;
        kill_q[tail] <= 1'b0;
        tail         <= tail + 1'b1;
      end
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
      pend  <= pend + (PTR_W + 1)'(push) - (PTR_W + 1)'(rsp_take);
    end
  end

  // Payload fields need no reset: they are only read once done is set.
  always_ff @(posedge clk) begin
    if (rsp_take) data_q[rsp_ptr] <= bus.dmem_rsp_rdata;
    if (push) begin
      rd_q[tail]   <= bus.req_rd;
      size_q[tail] <= bus.req_size;
      uns_q[tail]  <= bus.req_unsigned;
      off_q[tail]  <= req_off;
    end
  end

`ifdef MEM_LOAD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads       <= '0;
      perf_full_cycles <= '0;
    end else begin
      if (bus.wb_valid & bus.wb_ready) perf_loads <= perf_loads + 32'd1;
      if (bus.req_valid & ~bus.req_we & ~misaligned & bus.dmem_req_ready &
          ~bus.flush & full)
        perf_full_cycles <= perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed and randomized stimulus for mem_load_unit,
// checked against a transaction-level queue model; writeback records are
// compared by a separate monitor against a scoreboard queue.
module tb_mem_load_unit;
  localparam int XLEN    = 64;
  localparam int DATA_WD = 64;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_load_unit_if #(.XLEN(XLEN), .DATA_WD(DATA_WD)) bus ();

`ifdef MEM_LOAD_PERF_EN
  logic [31:0] perf_loads, perf_full_cycles;
`endif

  mem_load_unit #(.XLEN(XLEN), .DATA_WD(DATA_WD), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MEM_LOAD_PERF_EN
    .perf_loads(perf_loads),
    .perf_full_cycles(perf_full_cycles),
`endif
    .bus(bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic        resp;
    logic        kill;
    logic [63:0] val;
  } ld_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] val;
  } wb_t;

  ld_t mq[$];   // outstanding loads, oldest first
  wb_t sb[$];   // records expected on the writeback port, in order

  int errors = 0;
  int checks = 0;

  // stimulus for the next cycle
  logic        st_rst, st_rv, st_we, st_uns, st_flush, st_drdy, st_rsp, st_wbr;
  logic [63:0] st_addr, st_wdata, st_rdata;
  logic [1:0]  st_size;
  logic [4:0]  st_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                         input logic [2:0] off, input logic uns);
    logic [63:0] v;
    logic [63:0] mask;
    int n;
    v = raw >> (off * 8);
    n = 8 << size;
    if (n == 64) return v;
    mask = (64'd1 << n) - 64'd1;
    v = v & mask;
    if (!uns && v[n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle();
    st_rst = 0; st_rv = 0; st_we = 0; st_flush = 0; st_drdy = 1;
    st_rsp = 0; st_wbr = 1; st_uns = 0;
  endtask

  task automatic set_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input logic [63:0] wdata);
    st_rv = 1; st_we = we; st_addr = addr; st_size = size; st_uns = uns;
    st_rd = rd; st_wdata = wdata;
  endtask

  // One clock cycle: drive at posedge+1, check and advance the model at +3.
  task automatic step();
    int          pidx;
    int          occ;
    logic        mis, full, exp_rdy, exp_err, exp_dv, exp_wbv, do_push, do_pop;
    logic [2:0]  off;
    logic [7:0]  strb;
    logic [63:0] bmask;
    @(posedge clk);
    #1;
    pidx = -1;
    for (int i = 0; i < mq.size(); i++) if (pidx < 0 && !mq[i].resp) pidx = i;
    if (pidx < 0 || st_rst) st_rsp = 0;  // never respond without a pending load
    rst                = st_rst;
    bus.flush          = st_flush;
    bus.req_valid      = st_rv;
    bus.req_we         = st_we;
    bus.req_addr       = st_addr;
    bus.req_size       = st_size;
    bus.req_unsigned   = st_uns;
    bus.req_rd         = st_rd;
    bus.req_wdata      = st_wdata;
    bus.dmem_req_ready = st_drdy;
    bus.dmem_rsp_valid = st_rsp;
    bus.dmem_rsp_rdata = st_rdata;
    bus.wb_ready       = st_wbr;
    #2;
    if (st_rst) begin
      chk("rst_req_ready", 64'(bus.req_ready), 0);
      chk("rst_dmem_req_valid", 64'(bus.dmem_req_valid), 0);
      chk("rst_wb_valid", 64'(bus.wb_valid), 0);
      chk("rst_misalign_err", 64'(bus.misalign_err), 0);
      mq.delete();
      sb.delete();
      return;
    end
    off     = st_addr[2:0];
    mis     = (int'(off) % (1 << st_size)) != 0;
    occ     = mq.size();
    full    = occ >= DEPTH;
    exp_err = st_rv & mis;
    exp_dv  = st_rv & !mis & !st_flush & (st_we | !full);
    exp_rdy = mis | (st_drdy & !st_flush & (st_we | !full));
    exp_wbv = (occ > 0) && mq[0].resp && !mq[0].kill;
    if (st_rv) begin
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("misalign_err", 64'(bus.misalign_err), 64'(exp_err));
      chk("dmem_req_valid", 64'(bus.dmem_req_valid), 64'(exp_dv));
      if (exp_dv) begin
        strb = 8'(((1 << (1 << st_size)) - 1) << off);
        bmask = '0;
        for (int b = 0; b < 8; b++) if (strb[b]) bmask[b*8 +: 8] = 8'hFF;
        chk("dmem_addr", bus.dmem_addr, {st_addr[63:3], 3'b000});
        chk("dmem_we", 64'(bus.dmem_we), 64'(st_we));
        chk("dmem_wstrb", 64'(bus.dmem_wstrb), 64'(strb));
        if (st_we)
          chk("dmem_wdata", bus.dmem_wdata & bmask, (st_wdata << (off * 8)) & bmask);
      end
    end
    chk("wb_valid", 64'(bus.wb_valid), 64'(exp_wbv));
    if (exp_wbv) begin
      chk("wb_rd_hold", 64'(bus.wb_rd), 64'(mq[0].rd));
      chk("wb_data_hold", bus.wb_data, mq[0].val);
    end
    do_push = exp_dv & st_drdy & !st_we;
    do_pop  = (occ > 0) && mq[0].resp && (mq[0].kill || st_wbr);
    if (exp_wbv && st_wbr) sb.push_back('{rd: mq[0].rd, val: mq[0].val});
    if (st_rsp) begin
      mq[pidx].resp = 1'b1;
      mq[pidx].val  = extend(st_rdata, mq[pidx].size, mq[pidx].off, mq[pidx].uns);
    end
    if (do_pop) void'(mq.pop_front());
    if (st_flush) for (int i = 0; i < mq.size(); i++) mq[i].kill = 1'b1;
    if (do_push)
      mq.push_back('{rd: st_rd, size: st_size, uns: st_uns, off: off,
                     resp: 1'b0, kill: 1'b0, val: 64'd0});
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while (mq.size() > 0 && n < 60) begin
      st_rsp = 1; st_rdata = {$urandom, $urandom};
      step();
      n++;
    end
    chk("drain_empty", 64'(mq.size()), 0);
    idle();
    step();
  endtask

  // Monitor: every accepted writeback record must match the scoreboard head.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", 64'(bus.wb_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("sb_wb_rd", 64'(bus.wb_rd), 64'(e.rd));
          chk("sb_wb_data", bus.wb_data, e.val);
        end
      end
    end
  end

  initial begin
    bus.flush = 0; bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0;
    bus.req_size = 0; bus.req_unsigned = 0; bus.req_rd = 0; bus.req_wdata = '0;
    bus.dmem_req_ready = 0; bus.dmem_rsp_valid = 0; bus.dmem_rsp_rdata = '0;
    bus.wb_ready = 0;
    st_addr = '0; st_wdata = '0; st_rdata = '0; st_size = 0; st_rd = 0;
    idle();

    // Reset with an aligned request pending: nothing may be accepted.
    st_rst = 1;
    set_req(1'b0, 64'h40, 2'd3, 1'b0, 5'd1, '0);
    repeat (3) step();
    idle();
    step();

    // Signed word load at offset 4.
    set_req(1'b0, 64'h1004, 2'd2, 1'b0, 5'd5, '0);
    step();
    idle();
    st_rsp = 1; st_rdata = 64'h80000000_00000000;
    step();
    idle();
    step();
    chk("t1_wb_rd", 64'(bus.wb_rd), 64'd5);
    chk("t1_wb_data", bus.wb_data, 64'hFFFFFFFF_80000000);
    step();

    // Queue fills after four loads; fifth accepted the cycle after a pop.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 64'h100 + 64'(i * 8), 2'd3, 1'b0, 5'(i + 1), '0);
      step();
    end
    set_req(1'b0, 64'h200, 2'd0, 1'b1, 5'd9, '0);
    step();
    chk("t2_full_block", 64'(bus.req_ready), 0);
    st_rsp = 1; st_rdata = {$urandom, $urandom};
    step();
    chk("t2_rsp_cycle_block", 64'(bus.req_ready), 0);
    st_rsp = 0;
    step();
    chk("t2_pop_cycle_block", 64'(bus.req_ready), 0);
    step();
    chk("t2_fifth_accept", 64'(bus.req_ready), 1);
    drain();

    // Halfword store at offset 6.
    set_req(1'b1, 64'h2006, 2'd1, 1'b0, 5'd0, 64'hBEEF);
    step();
    chk("t3_wstrb", 64'(bus.dmem_wstrb), 64'hC0);
    chk("t3_wdata_hi", 64'(bus.dmem_wdata[63:48]), 64'hBEEF);

    // Misaligned halfword load.
    set_req(1'b0, 64'h2003, 2'd1, 1'b0, 5'd7, '0);
    step();
    chk("t4_misalign_err", 64'(bus.misalign_err), 1);
    chk("t4_no_dmem_req", 64'(bus.dmem_req_valid), 0);
    idle();
    step();

    // Flush with two loads in flight: nothing written back, queue empties.
    set_req(1'b0, 64'h300, 2'd2, 1'b0, 5'd3, '0); step();
    set_req(1'b0, 64'h308, 2'd1, 1'b1, 5'd4, '0); step();
    idle(); st_flush = 1; step();
    idle(); st_rsp = 1; st_rdata = {$urandom, $urandom}; step();
    st_rsp = 1; st_rdata = {$urandom, $urandom}; step();
    idle(); step(); step();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 64'h400 + 64'(i * 8), 2'd3, 1'b0, 5'(10 + i), '0);
      step();
      chk("t5_post_flush_accept", 64'(bus.req_ready), 1);
    end
    drain();

    // Writeback backpressure: head holds while later responses arrive.
    set_req(1'b0, 64'h500, 2'd0, 1'b0, 5'd20, '0); step();
    set_req(1'b0, 64'h509, 2'd0, 1'b1, 5'd21, '0); step();
    idle(); st_wbr = 0;
    st_rsp = 1; st_rdata = 64'h0000_0000_0000_0081; step();
    st_rsp = 1; st_rdata = 64'h0000_0000_0000_F200; step();
    st_rsp = 0; step(); step();
    drain();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [2:0] o;
      idle();
      st_size = 2'($urandom_range(0, 3));
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) o = o & ~3'((1 << st_size) - 1);
      st_rv    = ($urandom_range(0, 9) < 6);
      st_we    = ($urandom_range(0, 3) == 0);
      st_uns   = 1'($urandom);
      st_rd    = 5'($urandom);
      st_addr  = {$urandom, $urandom_range(0, 255), 5'd0, o} & 64'h0000_FFFF_FFFF_FFFF;
      st_wdata = {$urandom, $urandom};
      st_flush = ($urandom_range(0, 29) == 0);
      st_drdy  = ($urandom_range(0, 3) != 0);
      st_rsp   = ($urandom_range(0, 1) == 0);
      st_rdata = {$urandom, $urandom};
      st_wbr   = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();
    idle();
    step();
    chk("sb_drained", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
